uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter (uart_snd-style: data/valid in, active/done out) between NREQ byte requesters.
- Accepts one byte per grant via valid/ready.
- Optionally prefixes each byte with a source-tag byte.
- Issues bytes to the transmitter one at a time, then enforces an inter-byte stop-bit gap.
- A watchdog recovers the block if the transmitter never reports done.

---
 rtl/uart_tx_sched.sv | 95 +++++++++
 tb/tb_uart_tx_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART byte transmitter with optional tag byte, stop gap and watchdog
module uart_tx_sched #(
    parameter int NREQ = 4,
    parameter int STOP_GAP = 0,
    parameter int TAG_EN = 0,
    parameter int TIMEOUT = 4096,
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        snd_data,
    output logic              snd_valid,
    input  logic              snd_active,
    input  logic              snd_done,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ISSUE_TAG, WAIT_TAG, ISSUE_DATA, WAIT_DATA, GAP} state_t;
    localparam int MX = TIMEOUT > STOP_GAP ? TIMEOUT : STOP_GAP;
    localparam int CW = $clog2(MX + 2);
    localparam state_t AFTER = STOP_GAP > 0 ? GAP : IDLE;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr, win;
    logic [7:0] byte_q, snd_data_d;
    logic found, snd_valid_d, in_wait, to, gap_end, accept;
    logic unused_active;
    assign unused_active = snd_active;
    assign in_wait = state == WAIT_TAG || state == WAIT_DATA;
    assign to = in_wait && !snd_done && TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    assign gap_end = cnt == CW'(STOP_GAP - 1);
    assign accept = state == IDLE && found;
    // first valid requester at or after ptr, wrapping
    always_comb begin
        int j;
        found = 1'b0;
        win = ptr;
        j = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win = IW'(j);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:       next = found ? (TAG_EN != 0 ? ISSUE_TAG : ISSUE_DATA) : IDLE;
            ISSUE_TAG:  next = WAIT_TAG;
            WAIT_TAG:   next = snd_done ? ISSUE_DATA : to ? AFTER : WAIT_TAG;
            ISSUE_DATA: next = WAIT_DATA;
            WAIT_DATA:  next = (snd_done || to) ? AFTER : WAIT_DATA;
            GAP:        next = gap_end ? IDLE : GAP;
            default:    next = IDLE;
        endcase
    end
    always_comb begin
        req_ready = accept ? NREQ'(1) << win : '0;
        busy = state != IDLE;
        err = to;
        snd_valid_d = next == ISSUE_TAG || next == ISSUE_DATA;
        snd_data_d = accept ? (TAG_EN != 0 ? (8'hA0 | 8'(win)) : req_data[8*win +: 8])
                   : (state == WAIT_TAG && snd_done) ? byte_q : snd_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ptr <= '0;
            grant_id <= '0;
            byte_q <= '0;
            snd_valid <= 1'b0;
            snd_data <= '0;
        end else begin
            cnt <= state != next ? '0 : cnt + 1'b1;
            snd_valid <= snd_valid_d;
            snd_data <= snd_data_d;
            if (accept) begin
                byte_q <= req_data[8*win +: 8];
                grant_id <= win;
                ptr <= win == IW'(NREQ - 1) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of arbitration, gap, tag, watchdog and reset behaviour
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [3:0] rv, tv, ready, t_ready;
    logic [31:0] rd, td;
    logic done, tdone, svalid, t_valid, busy, t_busy, err, t_err;
    logic [7:0] sdata, t_data;
    logic [1:0] gid, t_gid;
    int errors = 0;
    int checks = 0;
    int tcnt = 0;
    uart_tx_sched #(.NREQ(4), .STOP_GAP(3), .TAG_EN(0), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_ready(ready),
        .snd_data(sdata), .snd_valid(svalid), .snd_active(1'b0), .snd_done(done),
        .grant_id(gid), .busy(busy), .err(err));
    uart_tx_sched #(.NREQ(4), .STOP_GAP(0), .TAG_EN(1), .TIMEOUT(16)) u_tag (
        .clk(clk), .rst(rst), .req_valid(tv), .req_data(td), .req_ready(t_ready),
        .snd_data(t_data), .snd_valid(t_valid), .snd_active(1'b0), .snd_done(tdone),
        .grant_id(t_gid), .busy(t_busy), .err(t_err));
    always @(posedge clk) if (t_valid) tcnt <= tcnt + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // one full grant from an IDLE cycle: accept, issue, done, three gap cycles, back to IDLE
    task automatic xfer(input int id, input logic [7:0] d, input bit spur);
        #1 chk("accept_ready", 32'(ready), 32'd1 << id);
        tick();
        chk("issue_valid", 32'(svalid), 1);
        chk("issue_data", 32'(sdata), 32'(d));
        chk("grant_id", 32'(gid), id);
        chk("issue_ready", 32'(ready), 0);
        tick();
        chk("wait_valid", 32'(svalid), 0);
        chk("wait_busy", 32'(busy), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("gap1_busy", 32'(busy), 1);
        chk("gap1_ready", 32'(ready), 0);
        if (spur) done = 1'b1;
        tick();
        done = 1'b0;
        chk("gap2_busy", 32'(busy), 1);
        chk("gap2_ready", 32'(ready), 0);
        tick();
        chk("gap3_busy", 32'(busy), 1);
        chk("gap3_ready", 32'(ready), 0);
        chk("gap3_valid", 32'(svalid), 0);
        chk("gap3_err", 32'(err), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
    endtask
    initial begin
        rv = '0; rd = '0; done = 1'b0; tv = '0; td = '0; tdone = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(svalid), 0);
        chk("rst_data", 32'(sdata), 0);
        chk("rst_gid", 32'(gid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_t_valid", 32'(t_valid), 0);
        rst = 1'b0;
        rd = 32'h44552211;
        rv = 4'b0100;
        xfer(2, 8'h55, 1'b1);
        xfer(2, 8'h55, 1'b0);
        rv = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("spur_idle_busy", 32'(busy), 0);
        chk("spur_idle_valid", 32'(svalid), 0);
        chk("spur_idle_err", 32'(err), 0);
        tick();
        chk("spur_idle_valid2", 32'(svalid), 0);
        chk("spur_idle_busy2", 32'(busy), 0);
        rv = 4'b0001;
        #1 chk("pre_rst_ready", 32'(ready), 32'h1);
        tick();
        chk("pre_rst_issue", 32'(svalid), 1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(svalid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_gid", 32'(gid), 0);
        chk("mid_rst_err", 32'(err), 0);
        rst = 1'b0;
        rd = 32'h44332211;
        rv = 4'b1111;
        xfer(0, 8'h11, 1'b0);
        xfer(1, 8'h22, 1'b0);
        xfer(2, 8'h33, 1'b0);
        xfer(3, 8'h44, 1'b0);
        xfer(0, 8'h11, 1'b0);
        xfer(1, 8'h22, 1'b0);
        rv = 4'b1010;
        xfer(3, 8'h44, 1'b0);
        xfer(1, 8'h22, 1'b0);
        rv = 4'b0001;
        #1 chk("wd_ready", 32'(ready), 32'h1);
        tick();
        chk("wd_issue_valid", 32'(svalid), 1);
        chk("wd_issue_data", 32'(sdata), 32'h11);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("wd_err", 32'(err), (i == 16) ? 1 : 0);
            chk("wd_busy", 32'(busy), 1);
        end
        tick();
        chk("wd_after_err", 32'(err), 0);
        chk("wd_after_busy", 32'(busy), 1);
        chk("wd_after_valid", 32'(svalid), 0);
        rd[7:0] = 8'h5A;
        tick();
        tick();
        chk("wd_gap_busy", 32'(busy), 1);
        chk("wd_gap_ready", 32'(ready), 0);
        tick();
        chk("wd_idle_busy", 32'(busy), 0);
        xfer(0, 8'h5A, 1'b0);
        rv = '0;
        tv = 4'b0010;
        td = 32'h00003C00;
        #1 chk("tag_ready", 32'(t_ready), 32'h2);
        tick();
        chk("tag_valid", 32'(t_valid), 1);
        chk("tag_data", 32'(t_data), 32'hA1);
        chk("tag_gid", 32'(t_gid), 1);
        tv = '0;
        tick();
        chk("tag_wait_valid", 32'(t_valid), 0);
        chk("tag_wait_busy", 32'(t_busy), 1);
        tick();
        tdone = 1'b1;
        tick();
        tdone = 1'b0;
        chk("tag_payload_valid", 32'(t_valid), 1);
        chk("tag_payload_data", 32'(t_data), 32'h3C);
        tick();
        chk("tag_payload_wait", 32'(t_valid), 0);
        tdone = 1'b1;
        tv = 4'b0001;
        #1 chk("tag_wait_ready", 32'(t_ready), 0);
        tick();
        tdone = 1'b0;
        chk("tag_idle_busy", 32'(t_busy), 0);
        #1 chk("tag_nogap_ready", 32'(t_ready), 32'h1);
        chk("tag_pulse_count", 32'(tcnt), 2);
        tv = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
